multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Moore-style control FSM that sequences the multicycle MIPS datapath (PC, IR,
//  unified memory, regFile, ALU) through FETCH/DECODE/EXEC/MEM/WB steps.
//  Supports lw, sw, R-type add/sub/and/or/slt, beq, bne and j.
//  Stretches memory states on a ready handshake from the shared memory port.
// PARAMETERS
//  CNT_W    32  width of the performance counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk            in   1      system clock, all state updates on posedge
//  rst_n          in   1      asynchronous active-low reset
//  opcode         in   6      IR[31:26], valid from DECODE onward
//  zero           in   1      ALU zero flag, sampled in BRANCH
//  mem_ready      in   1      memory completes the current access this cycle
//  pc_en          out  1      PC load enable (fetch increment, taken branch, jump)
//  pc_src         out  2      0 = ALU result, 1 = ALUOut (branch target), 2 = jump target
//  i_or_d         out  1      memory address select: 0 = PC, 1 = ALUOut
//  mem_read       out  1      memory read strobe
//  mem_write      out  1      memory write strobe
//  ir_write       out  1      IR load enable
//  reg_dst        out  1      write register: 0 = rt, 1 = rd
//  mem_to_reg     out  1      write data: 0 = ALUOut, 1 = MDR
//  reg_write      out  1      regFile write enable
//  alu_src_a      out  1      0 = PC, 1 = A register
//  alu_src_b      out  2      0 = B, 1 = 4, 2 = sign-extended imm, 3 = imm << 2
//  alu_op         out  2      0 = add, 1 = sub, 2 = decode funct
//  illegal        out  1      one-cycle pulse in DECODE for an unsupported opcode
//  state          out  4      current state encoding, for debug
// BEHAVIOUR
//  - States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5,
//    EXEC=6, RTWB=7, BRANCH=8, JUMP=9. Any other encoding returns to FETCH.
//  - Reset (async, rst_n=0): state=FETCH immediately. All outputs derive from state,
//    so reset values are the FETCH values.
//  - Gating in FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0 and
//    pc_src=0. pc_en and ir_write equal mem_ready.
//  - Stalls: the FSM holds FETCH, MEMRD and MEMWR while mem_ready=0.
//  - FETCH -> DECODE on mem_ready=1. DECODE computes the branch target with
//    alu_src_a=0, alu_src_b=3 and alu_op=0.
//  - DECODE branches by opcode: 0x23/0x2B -> MEMADR, 0x00 -> EXEC,
//    0x04/0x05 -> BRANCH, 0x02 -> JUMP. Any other opcode pulses illegal=1 and goes
//    to FETCH; the instruction is a no-op.
//  - MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEMRD for lw and MEMWR for sw.
//  - MEMRD: mem_read=1, i_or_d=1. Goes to MEMWB on mem_ready.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
//  - MEMWR: mem_write=1, i_or_d=1, held until mem_ready. Goes to FETCH on mem_ready.
//  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Goes to RTWB.
//  - RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
//    pc_en = (opcode==0x04 & zero) | (opcode==0x05 & ~zero). Goes to FETCH.
//  - JUMP: pc_en=1, pc_src=2. Goes to FETCH.
//  - Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, beq/bne 3, j 3.
//  - Strobes: mem_read and mem_write are never both 1. reg_write and pc_en are never
//    both 1 in the same cycle.
//  - Reset asserted mid-instruction abandons the instruction. No write strobe is
//    asserted while rst_n=0.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: extra outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0].
//   - Both reset to 0.
//   - cycle_cnt increments every clock with rst_n=1.
//   - instr_cnt increments on each transition into FETCH from another state,
//     including illegal opcodes.
//   - Both wrap modulo 2^CNT_W.
//  MC_PERF_CNT_EN undefined: these ports and their registers do not exist. FSM
//   behaviour is identical.
// TESTING
//  - Reset: rst_n=0 at t=0, release after 2 clocks -> state=0, mem_read=1, ir_write=0
//    while mem_ready=0. Drive mem_ready=1 -> ir_write=1 and pc_en=1 the same cycle.
//  - lw $4,2($1) (8C240002), mem_ready=1 -> states 0,1,2,3,4,0.
//    reg_write=1 with mem_to_reg=1 only in state 4.
//  - sw $3,64($0) (AC030040) with mem_ready low for 3 cycles in MEMWR -> mem_write
//    held 4 cycles, then state 0. reg_write stays 0 throughout.
//  - add $7,$5,$6 (00A63820) -> states 0,1,6,7,0. alu_op=2 in state 6.
//    reg_dst=1 and reg_write=1 in state 7.
//  - beq (1109FFFF): zero=1 -> pc_en=1 with pc_src=1. bne (1509FFFF): zero=1 -> pc_en=0.
//    j 2 (08000002) -> pc_en=1 with pc_src=2.
//  - Opcode 0x3F -> illegal=1 for one cycle in DECODE, then FETCH.
//    With MC_PERF_CNT_EN, instr_cnt increments by 1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller drives through the master modport; the datapath connects to slave.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath (lw/sw/R-type/beq/bne/j).
// Define MC_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  logic pc_en_c;
  logic ir_write_c;
  logic mem_write_c;
  logic reg_write_c;
  logic branch_taken;

  // Counter width must be at least one bit, whether or not the counters are built.
  if (CNT_W == 0) begin : g_cnt_w_invalid
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign branch_taken = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                        ((bus.opcode == OP_BNE) && !bus.zero);

  always_comb begin
    state_d         = FETCH;
    pc_en_c         = 1'b0;
    ir_write_c      = 1'b0;
    mem_write_c     = 1'b0;
    reg_write_c     = 1'b0;
    bus.pc_src      = 2'd0;
    bus.i_or_d      = 1'b0;
    bus.mem_read    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'd0;
    bus.alu_op      = 2'd0;
    bus.illegal     = 1'b0;

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'd1;
        pc_en_c       = bus.mem_ready;
        ir_write_c    = bus.mem_ready;
        state_d       = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'd3;
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          default: begin
            bus.illegal = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        state_d       = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_d      = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_c    = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        mem_write_c = 1'b1;
        bus.i_or_d  = 1'b1;
        state_d     = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'd2;
        state_d       = RTWB;
      end
      RTWB: begin
        reg_write_c = 1'b1;
        bus.reg_dst = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'd1;
        bus.pc_src    = 2'd1;
        pc_en_c       = branch_taken;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_en_c    = 1'b1;
        bus.pc_src = 2'd2;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write-type strobes are forced low while reset is held, so nothing is committed
  // between the reset edge and the next clock.
  assign bus.pc_en     = pc_en_c     & rst_n;
  assign bus.ir_write  = ir_write_c  & rst_n;
  assign bus.mem_write = mem_write_c & rst_n;
  assign bus.reg_write = reg_write_c & rst_n;
  assign bus.state     = state_q;

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((state_d == FETCH) && (state_q != FETCH)) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
